// File: rtl/rans_cdf_table.sv
// rans_cdf_table
//   Symbol-statistics stage in front of the rANS encoder core. The host writes
//   per-symbol frequencies. build_start runs a sequential prefix sum, one entry
//   per cycle, to fill the cumulative-frequency table. The total is then checked
//   against 2^RESOLUTION. While the table is valid, the block serves
//   (freq, cum) lookups with a valid/ready handshake.
//
// Ports
//   clk, rst                       clock / asynchronous active-high reset
//   freq_wr_en/_sym/_val           frequency table write
//   build_start                    pulse: start CDF build
//   busy, table_ready, err_sum     status
//   sym_valid, sym, sym_ready      lookup request handshake
//   out_valid, out_sym, out_freq,
//   out_cum, out_ready             lookup result handshake
module rans_cdf_table #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freq_wr_en,
    input  logic [SYMBOL_WIDTH-1:0] freq_wr_sym,
    input  logic [RESOLUTION:0]     freq_wr_val,
    input  logic                    build_start,
    output logic                    busy,
    output logic                    table_ready,
    output logic                    err_sum,
    input  logic                    sym_valid,
    input  logic [SYMBOL_WIDTH-1:0] sym,
    output logic                    sym_ready,
    output logic                    out_valid,
    output logic [SYMBOL_WIDTH-1:0] out_sym,
    output logic [RESOLUTION:0]     out_freq,
    output logic [RESOLUTION:0]     out_cum,
    input  logic                    out_ready
);
    localparam int N     = 1 << SYMBOL_WIDTH;
    localparam int ACC_W = SYMBOL_WIDTH + RESOLUTION + 1;
    localparam logic [ACC_W-1:0] FULL = ACC_W'(1) << RESOLUTION;

    typedef enum logic [1:0] {S_IDLE, S_BUILD, S_READY} state_e;

    state_e                  state_q;
    logic [SYMBOL_WIDTH:0]   idx_q;   // MSB set => all entries done, compare cycle
    logic [ACC_W-1:0]        acc_q;
    logic                    err_q;
    logic                    ov_q;
    logic [SYMBOL_WIDTH-1:0] osym_q;
    logic [RESOLUTION:0]     ofreq_q;
    logic [RESOLUTION:0]     ocum_q;

    logic [RESOLUTION:0] freq_mem [N];
    logic [RESOLUTION:0] cum_mem  [N];

    logic                    wr_ok;
    logic                    start_ok;
    logic                    accept;
    logic                    build_entry;
    logic [SYMBOL_WIDTH-1:0] idx_lo;

    // A write takes priority over a simultaneous build_start.
    assign wr_ok       = freq_wr_en && (state_q != S_BUILD);
    assign start_ok    = build_start && !freq_wr_en && (state_q != S_BUILD);
    assign sym_ready   = (state_q == S_READY) && (!ov_q || out_ready);
    assign accept      = sym_valid && sym_ready;
    assign idx_lo      = idx_q[SYMBOL_WIDTH-1:0];
    assign build_entry = (state_q == S_BUILD) && !idx_q[SYMBOL_WIDTH];

    assign busy        = (state_q == S_BUILD);
    assign table_ready = (state_q == S_READY);
    assign err_sum     = err_q;
    assign out_valid   = ov_q;
    assign out_sym     = osym_q;
    assign out_freq    = ofreq_q;
    assign out_cum     = ocum_q;

    // Table storage has no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            freq_mem[freq_wr_sym] <= freq_wr_val;
        end
        if (build_entry) begin
            cum_mem[idx_lo] <= acc_q[RESOLUTION:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            osym_q  <= '0;
            ofreq_q <= '0;
            ocum_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_READY: begin
                    if (wr_ok) begin
                        state_q <= S_IDLE;
                    end else if (start_ok) begin
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        state_q <= S_BUILD;
                    end
                end
                S_BUILD: begin
                    if (!idx_q[SYMBOL_WIDTH]) begin
                        acc_q <= acc_q + ACC_W'(freq_mem[idx_lo]);
                        idx_q <= idx_q + 1'b1;
                    end else if (acc_q == FULL) begin
                        state_q <= S_READY;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // A held result still completes its handshake after leaving READY.
            if (accept) begin
                ov_q    <= 1'b1;
                osym_q  <= sym;
                ofreq_q <= freq_mem[sym];
                ocum_q  <= cum_mem[sym];
            end else if (out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rans_cdf_table.sv
module tb_rans_cdf_table;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freq_wr_en = 1'b0;
    logic [7:0]  freq_wr_sym = '0;
    logic [10:0] freq_wr_val = '0;
    logic        build_start = 1'b0;
    logic        busy, table_ready, err_sum;
    logic        sym_valid = 1'b0;
    logic [7:0]  sym = '0;
    logic        sym_ready;
    logic        out_valid;
    logic [7:0]  out_sym;
    logic [10:0] out_freq, out_cum;
    logic        out_ready = 1'b0;

    rans_cdf_table #(.RESOLUTION(10), .SYMBOL_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .freq_wr_en(freq_wr_en), .freq_wr_sym(freq_wr_sym), .freq_wr_val(freq_wr_val),
        .build_start(build_start), .busy(busy), .table_ready(table_ready), .err_sum(err_sum),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
        .out_valid(out_valid), .out_sym(out_sym), .out_freq(out_freq), .out_cum(out_cum),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: frequency list, table-valid flag, pending result.
    int         freq_m [256];
    bit         m_tr = 1'b0;
    bit         m_ov = 1'b0;
    logic [7:0] m_osym;
    int         m_ofreq, m_ocum;
    logic [7:0] got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cum_of(input int s);
        int c = 0;
        for (int i = 0; i < s; i++) c += freq_m[i];
        return c;
    endfunction

    function automatic int total();
        int c = 0;
        for (int i = 0; i < 256; i++) c += freq_m[i];
        return c;
    endfunction

    task automatic wr(input int s, input int v);
        freq_wr_en = 1'b1; freq_wr_sym = 8'(s); freq_wr_val = 11'(v);
        @(posedge clk); #1;
        freq_wr_en = 1'b0;
        freq_m[s] = v;
        m_tr = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < 256; i++) wr(i, freq_m[i]);
    endtask

    // Build and measure busy duration; optionally inject a write mid-build.
    task automatic build(input int wr_at);
        int n = 0;
        bit ok;
        ok = (total() == 1024);
        build_start = 1'b1;
        @(posedge clk); #1;
        build_start = 1'b0;
        while (busy === 1'b1 && n < 400) begin
            if (n == wr_at) begin
                freq_wr_en = 1'b1; freq_wr_sym = 8'd0; freq_wr_val = 11'd100;
            end
            @(posedge clk); #1;
            freq_wr_en = 1'b0;
            n++;
        end
        chk("busy_cycles", n, 257);
        chk("table_ready", table_ready, ok);
        chk("err_sum", err_sum, !ok);
        m_tr = ok;
    endtask

    // One handshake cycle, checked against the model.
    task automatic cyc(input bit v, input logic [7:0] s, input bit r, output bit acc);
        sym_valid = v; sym = s; out_ready = r;
        #1;
        chk("sym_ready", sym_ready, m_tr && (!m_ov || r));
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_sym", out_sym, m_osym);
            chk("out_freq", out_freq, m_ofreq);
            chk("out_cum", out_cum, m_ocum);
        end
        if (out_valid === 1'b1 && r) got.push_back(out_sym);
        acc = v && m_tr && (!m_ov || r);
        @(posedge clk); #1;
        sym_valid = 1'b0; out_ready = 1'b0;
        if (acc) begin
            m_ov = 1'b1; m_osym = s; m_ofreq = freq_m[s]; m_ocum = cum_of(s);
        end else if (r) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic rand_lookups(input int n, input int bp_pct);
        int sent = 0;
        bit acc;
        for (int c = 0; c < 20 * n + 20 && (sent < n || m_ov); c++) begin
            cyc(sent < n, 8'($urandom), $urandom_range(0, 99) >= bp_pct, acc);
            if (acc) sent++;
        end
        chk("lookups_sent", sent, n);
    endtask

    initial begin
        bit acc;
        int pi;
        logic [7:0] p [3];
        bit rp [8];

        for (int i = 0; i < 256; i++) freq_m[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_table_ready", table_ready, 0);
        chk("rst_err_sum", err_sum, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sym", out_sym, 0);
        chk("rst_out_freq", out_freq, 0);
        chk("rst_out_cum", out_cum, 0);
        rst = 1'b0;
        #1;
        chk("rst_sym_ready", sym_ready, 0);

        // Uniform table
        for (int i = 0; i < 256; i++) freq_m[i] = 4;
        load_table();
        build(-1);
        cyc(1'b1, 8'd5, 1'b1, acc);
        chk("uni5_freq", out_freq, 4);
        chk("uni5_cum", out_cum, 20);
        cyc(1'b1, 8'd255, 1'b1, acc);
        chk("uni255_freq", out_freq, 4);
        chk("uni255_cum", out_cum, 1020);
        cyc(1'b0, 8'd0, 1'b1, acc);
        rand_lookups(40, 30);

        // Skewed table
        for (int i = 0; i < 256; i++) freq_m[i] = 0;
        freq_m[0] = 1000; freq_m[255] = 24;
        load_table();
        build(-1);
        cyc(1'b1, 8'd255, 1'b1, acc);
        chk("skew255_freq", out_freq, 24);
        chk("skew255_cum", out_cum, 1000);
        cyc(1'b1, 8'd7, 1'b1, acc);
        chk("skew7_freq", out_freq, 0);
        chk("skew7_cum", out_cum, 1000);
        cyc(1'b0, 8'd0, 1'b1, acc);

        // Random normalised tables
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 256; i++) freq_m[i] = 0;
            for (int k = 0; k < 64; k++) freq_m[$urandom_range(0, 255)] += 16;
            load_table();
            build(-1);
            rand_lookups(50, 40);
        end

        // Bad sum (1023)
        for (int i = 0; i < 256; i++) freq_m[i] = 4;
        freq_m[9] = 3;
        load_table();
        build(-1);
        cyc(1'b1, 8'd9, 1'b1, acc);

        // Backpressure: 1,2,3 with out_ready low for three cycles after the first
        wr(9, 4);
        build(-1);
        got.delete();
        p = '{8'd1, 8'd2, 8'd3};
        rp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        pi = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(pi < 3, p[pi < 3 ? pi : 0], rp[c], acc);
            if (acc) pi++;
        end
        chk("bp_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("bp_order", got[i], i + 1);

        // Write + build_start same cycle from READY: write wins, no build
        freq_wr_en = 1'b1; build_start = 1'b1; freq_wr_sym = 8'd3; freq_wr_val = 11'd4;
        @(posedge clk); #1;
        freq_wr_en = 1'b0; build_start = 1'b0; m_tr = 1'b0;
        chk("wrbuild_busy", busy, 0);
        chk("wrbuild_ready", table_ready, 0);
        @(posedge clk); #1;
        chk("wrbuild_busy2", busy, 0);

        // Write during BUILD is ignored
        build(10);
        cyc(1'b1, 8'd0, 1'b1, acc);
        chk("wrbusy_freq0", out_freq, 4);
        cyc(1'b1, 8'd5, 1'b1, acc);
        chk("wrbusy_cum5", out_cum, 20);
        cyc(1'b0, 8'd0, 1'b1, acc);

        // Write in READY with a held result: table drops, result still delivered
        cyc(1'b1, 8'd7, 1'b1, acc);
        cyc(1'b0, 8'd0, 1'b0, acc);
        wr(3, 4);
        chk("wrready_table", table_ready, 0);
        chk("wrready_held_valid", out_valid, 1);
        chk("wrready_held_sym", out_sym, 7);
        cyc(1'b0, 8'd0, 1'b1, acc);
        cyc(1'b0, 8'd0, 1'b0, acc);

        // Reset at build index 100
        build_start = 1'b1;
        @(posedge clk); #1;
        build_start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("prerst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", table_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_tr = 1'b0; m_ov = 1'b0;
        build(-1);
        rand_lookups(20, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
